serial_frame_collector: RTL
===========================

Name: serial_frame_collector

Overview:
- Downstream consumer of the BCD-counter / memory / 16:1 bit-select chain.
- Samples the serialised bit stream together with the counter state that produced each bit, and reassembles one parallel frame per counter cycle (indices 0..FRAME_LEN-1).
- Checks index sequencing and buffers completed frames in a small FIFO.
- Hands frames to the next stage over a valid/ready handshake.

Parameters:
- FRAME_LEN, 10: bits per frame; equals the BCD counter modulus. Legal range 2..16.
- IDX_W, 4: width of the index input.
- FIFO_DEPTH, 2: completed-frame buffer entries. Power of two.

Ports:
- clk, in, 1: single clock, rising edge. The upstream counter changes on falling edges, so inputs are stable at the rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- bit_in, in, 1: serial data bit (the mux output).
- idx_in, in, IDX_W: counter state that selected bit_in.
- sample_en, in, 1: qualifies bit_in/idx_in this cycle.
- frame_data, out, FRAME_LEN: head-of-FIFO frame; bit i = bit sampled at idx i.
- frame_ones, out, 5: popcount of frame_data.
- frame_valid, out, 1: FIFO non-empty.
- frame_ready, in, 1: consumer accepts the head frame.
- seq_err, out, 1: one-cycle pulse on an index sequence violation.
- overflow, out, 1: one-cycle pulse when a completed frame is dropped.
- frame_cnt, out, 8: count of frames pushed; wraps 255->0.

Behaviour:
- Reset (rst_n=0 at a rising edge) has priority over everything and produces:
  - state HUNT, FIFO empty, partial frame cleared;
  - frame_valid=0, frame_data=0, frame_ones=0;
  - seq_err=0, overflow=0, frame_cnt=0.
- Reset mid-frame discards the partial frame and all buffered frames.
- Sampling: acts only when sample_en=1. When sample_en=0, the state, expected index and partial frame all hold.
- FSM state HUNT:
  - A sample with idx_in==0 stores bit_in at position 0, sets expect=1 and goes to COLLECT.
  - Any other sample is ignored and does not raise seq_err.
- FSM state COLLECT, sample with idx_in==expect:
  - Store bit_in at position expect.
  - If expect==FRAME_LEN-1, the frame is complete: push it and set expect=0, staying in COLLECT so back-to-back frames need no gap.
  - Otherwise expect++.
- FSM state COLLECT, sample with idx_in!=expect (including idx_in>=FRAME_LEN):
  - seq_err pulses for 1 cycle and the partial frame is discarded.
  - If idx_in==0, the sample starts a new frame: store bit 0, set expect=1, stay in COLLECT.
  - Otherwise go to HUNT.
- Push:
  - frame_ones is computed from the completed frame and stored alongside it.
  - frame_cnt increments only on a successful push.
- Latency: a frame completed at rising edge N shows frame_valid=1 with its data from the cycle after edge N, if the FIFO was empty.
- Pop: occurs when frame_valid && frame_ready at a rising edge; the next entry appears the following cycle.
- Full FIFO:
  - Push with no simultaneous pop drops the new frame, pulses overflow, and leaves frame_cnt unchanged.
  - Push with a simultaneous pop is accepted, with no overflow.
- Empty FIFO: frame_ready is ignored, and frame_data/frame_ones hold their last value (don't-care).
- Order is strictly FIFO.
- All outputs are registered or driven directly from FIFO head registers; there is no combinational path from any input to any output.

Test Plan:
1. Reset; ready=1, sample_en=1. Feed idx 0..9 with bits 1,0,1,1,0,0,0,0,0,1. Required: frame_data=10'h20D, frame_ones=4, frame_valid high exactly 1 cycle, frame_cnt=1, no seq_err.
2. Start stream at idx 5..9, then 0..9 all zero. Required: idx 5..9 ignored with no seq_err; one frame with frame_data=0, frame_ones=0, frame_cnt=1.
3. Feed idx 0,1,2,4, then 0..9 all ones. Required: seq_err pulse on the idx=4 sample; then one frame with frame_data=10'h3FF, frame_ones=10, frame_cnt=1.
4. frame_ready=0; three consecutive frames 10'h001, 10'h002, 10'h004. Required:
   - overflow pulses on the third;
   - frame_cnt=2;
   - raising ready yields 10'h001 then 10'h002, then valid=0.
5. Full FIFO with ready=1 on the cycle a third frame completes. Required: pop and push both occur, no overflow, frame_cnt=3.
6. rst_n=0 for one cycle after idx 6 of a frame, with one frame buffered; then idx 7..9 followed by 0..9. Required:
   - immediately after reset, valid=0 and frame_cnt=0;
   - idx 7..9 ignored;
   - the subsequent frame is collected normally and frame_cnt=1.

Source files
------------

// File: rtl/serial_frame_collector.sv
`default_nettype none
// ============================================================================
// Module : serial_frame_collector
// Reassembles index-tagged serial bits into parallel frames and queues them
// in a small FIFO for a valid/ready consumer.
// Rev    : 1.0 - initial release
// ============================================================================
module serial_frame_collector #(
    parameter int FRAME_LEN  = 10,
    parameter int IDX_W      = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic [IDX_W-1:0]     idx_in,
    input  logic                 sample_en,
    output logic [FRAME_LEN-1:0] frame_data,
    output logic [4:0]           frame_ones,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 seq_err,
    output logic                 overflow,
    output logic [7:0]           frame_cnt
);
    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0]   c_last_idx = IDX_W'(FRAME_LEN - 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(FIFO_DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                                 state_q, state_d;
    logic [IDX_W-1:0]                       expect_q, expect_d;
    logic [FRAME_LEN-1:0]                   partial_q, partial_d;
    logic [FIFO_DEPTH-1:0][FRAME_LEN-1:0]   data_q, data_d;
    logic [FIFO_DEPTH-1:0][4:0]             ones_q, ones_d;
    logic [c_ptr_w-1:0]                     wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]                     rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]                     count_q, count_d;
    logic                                   seq_err_q, seq_err_d;
    logic                                   overflow_q, overflow_d;
    logic [7:0]                             frame_cnt_q, frame_cnt_d;

    logic [FRAME_LEN-1:0] w_frame;
    logic [4:0]           w_ones;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_accept;

    // Partial frame with the current sample merged in at the expected slot.
    always_comb begin
        w_frame = partial_q;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (expect_q == IDX_W'(i)) begin
                w_frame[i] = bit_in;
            end
        end
        w_ones = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            w_ones = w_ones + {4'b0000, w_frame[i]};
        end
    end

    always_comb begin
        state_d   = state_q;
        expect_d  = expect_q;
        partial_d = partial_q;
        seq_err_d = 1'b0;
        w_push    = 1'b0;
        if (sample_en) begin
            case (state_q)
                HUNT: begin
                    if (idx_in == '0) begin
                        partial_d = {{(FRAME_LEN-1){1'b0}}, bit_in};
                        expect_d  = IDX_W'(1);
                        state_d   = COLLECT;
                    end
                end
                COLLECT: begin
                    if (idx_in == expect_q) begin
                        if (expect_q == c_last_idx) begin
                            w_push    = 1'b1;
                            expect_d  = '0;
                            partial_d = '0;
                        end else begin
                            partial_d = w_frame;
                            expect_d  = expect_q + 1'b1;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        if (idx_in == '0) begin
                            partial_d = {{(FRAME_LEN-1){1'b0}}, bit_in};
                            expect_d  = IDX_W'(1);
                        end else begin
                            partial_d = '0;
                            expect_d  = '0;
                            state_d   = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // A full FIFO still takes a push when the head leaves on the same edge.
    always_comb begin
        w_pop    = (count_q != '0) && frame_ready;
        w_full   = (count_q == c_full_cnt);
        w_accept = w_push && (!w_full || w_pop);

        data_d      = data_q;
        ones_d      = ones_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = w_push && !w_accept;
        frame_cnt_d = frame_cnt_q;

        if (w_accept) begin
            data_d[wr_ptr_q] = w_frame;
            ones_d[wr_ptr_q] = w_ones;
            wr_ptr_d         = (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + 1'b1;
            frame_cnt_d      = frame_cnt_q + 8'd1;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({w_accept, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            expect_q    <= '0;
            partial_q   <= '0;
            data_q      <= '0;
            ones_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            seq_err_q   <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            expect_q    <= expect_d;
            partial_q   <= partial_d;
            data_q      <= data_d;
            ones_q      <= ones_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            seq_err_q   <= seq_err_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_data  = data_q[rd_ptr_q];
    assign frame_ones  = ones_q[rd_ptr_q];
    assign frame_valid = (count_q != '0);
    assign seq_err     = seq_err_q;
    assign overflow    = overflow_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire
